// File: rtl/riscv_wb_pkg.sv
// Shared constants and the writeback request type used by the
// writeback unit and its ALU result FIFO.
package riscv_wb_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests with registered occupancy count.
// Pointers wrap modulo DEPTH, which must be a power of two.
module wb_fifo
    import riscv_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clock_i,
    input  logic    reset_i,
    input  logic    push_i,
    input  wb_req_t push_data_i,
    input  logic    pop_i,
    output wb_req_t head_o,
    output logic    full_o,
    output logic    empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_req_t         r_mem [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;

    assign full_o  = (r_count == CW'(DEPTH));
    assign empty_o = (r_count == '0);
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign head_o  = r_mem[r_rptr];

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clock_i) begin
        if (w_push) r_mem[r_wptr] <= push_data_i;
    end
endmodule

// File: rtl/regfile_writeback_unit.sv
// Writeback stage owning the register-file write port: loads bypass and win,
// ALU results queue in a FIFO; also keeps the per-register busy scoreboard.
module regfile_writeback_unit
    import riscv_wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              alu_valid_i,
    input  logic [ADDR_W-1:0] alu_rd_i,
    input  logic [DATA_W-1:0] alu_data_i,
    output logic              alu_ready_o,
    input  logic              mem_valid_i,
    input  logic [ADDR_W-1:0] mem_rd_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              issue_valid_i,
    input  logic [ADDR_W-1:0] issue_rd_i,
    output logic [NREGS-1:0]  busy_o,
    output logic              write_ena_o,
    output logic [ADDR_W-1:0] W_adress_o,
    output logic [DATA_W-1:0] d_o,
    output logic              err_o
);
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [NREGS-1:0]  r_busy;
    logic              r_err;

    logic              w_full;
    logic              w_empty;
    logic              w_alu_acc;
    logic              w_push;
    logic              w_pop;
    wb_req_t           w_push_req;
    wb_req_t           w_head;
    logic [NREGS-1:0]  w_busy_nxt;
    logic              w_err_issue;
    logic              w_err_res;

    assign alu_ready_o = !w_full;
    assign w_alu_acc   = alu_valid_i && alu_ready_o;
    // rd=0 results are accepted but never occupy a FIFO slot.
    assign w_push      = w_alu_acc && (alu_rd_i != '0);
    assign w_pop       = !mem_valid_i && !w_empty;
    assign w_push_req  = '{rd: alu_rd_i, data: alu_data_i};

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .push_i      (w_push),
        .push_data_i (w_push_req),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .full_o      (w_full),
        .empty_o     (w_empty)
    );

    // Clear on the commit edge, then set, so a re-issue racing its own write stays busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_we) w_busy_nxt[r_addr] = 1'b0;
        if (issue_valid_i && issue_rd_i != '0) w_busy_nxt[issue_rd_i] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    assign w_err_issue = issue_valid_i && (issue_rd_i != '0) && r_busy[issue_rd_i]
                         && !(r_we && r_addr == issue_rd_i);
    assign w_err_res   = (w_alu_acc && (alu_rd_i != '0) && !r_busy[alu_rd_i])
                         || (mem_valid_i && (mem_rd_i != '0) && !r_busy[mem_rd_i]);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_err_issue || w_err_res) r_err <= 1'b1;
            if (mem_valid_i) begin
                r_we <= (mem_rd_i != '0);
                if (mem_rd_i != '0) begin
                    r_addr <= mem_rd_i;
                    r_data <= mem_data_i;
                end
            end else if (w_pop) begin
                r_we   <= 1'b1;
                r_addr <= w_head.rd;
                r_data <= w_head.data;
            end else begin
                r_we <= 1'b0;
            end
        end
    end

    assign write_ena_o = r_we;
    assign W_adress_o  = r_addr;
    assign d_o         = r_data;
    assign busy_o      = r_busy;
    assign err_o       = r_err;
endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Directed scenarios with literal expectations, then random legal traffic,
// all checked every cycle against a queue-based model of the writeback rules.
module tb_regfile_writeback_unit;
    import riscv_wb_pkg::*;

    localparam int DEPTH = 4;

    logic              clock_i = 1'b0;
    logic              reset_i = 1'b1;
    logic              alu_valid_i = 1'b0;
    logic [ADDR_W-1:0] alu_rd_i = '0;
    logic [DATA_W-1:0] alu_data_i = '0;
    logic              alu_ready_o;
    logic              mem_valid_i = 1'b0;
    logic [ADDR_W-1:0] mem_rd_i = '0;
    logic [DATA_W-1:0] mem_data_i = '0;
    logic              issue_valid_i = 1'b0;
    logic [ADDR_W-1:0] issue_rd_i = '0;
    logic [NREGS-1:0]  busy_o;
    logic              write_ena_o;
    logic [ADDR_W-1:0] W_adress_o;
    logic [DATA_W-1:0] d_o;
    logic              err_o;

    regfile_writeback_unit #(.FIFO_DEPTH(DEPTH)) dut (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .alu_valid_i   (alu_valid_i),
        .alu_rd_i      (alu_rd_i),
        .alu_data_i    (alu_data_i),
        .alu_ready_o   (alu_ready_o),
        .mem_valid_i   (mem_valid_i),
        .mem_rd_i      (mem_rd_i),
        .mem_data_i    (mem_data_i),
        .issue_valid_i (issue_valid_i),
        .issue_rd_i    (issue_rd_i),
        .busy_o        (busy_o),
        .write_ena_o   (write_ena_o),
        .W_adress_o    (W_adress_o),
        .d_o           (d_o),
        .err_o         (err_o)
    );

    always #5 clock_i = ~clock_i;

    int ncmp = 0;
    int nbad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of pending ALU results plus busy bits.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_busy = '0;
    bit          m_err = 0;
    bit          m_we = 0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    bit          m_alu_acc = 0;

    always @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            mq.delete();
            m_busy = '0; m_err = 0; m_we = 0; m_addr = '0; m_data = '0; m_alu_acc = 0;
        end else begin
            bit          acc;
            logic [31:0] nb;
            ent_t        e;
            acc = alu_valid_i && (mq.size() < DEPTH);
            if (issue_valid_i && issue_rd_i != 0 && m_busy[issue_rd_i] && !(m_we && m_addr == issue_rd_i)) m_err = 1;
            if (acc && alu_rd_i != 0 && !m_busy[alu_rd_i]) m_err = 1;
            if (mem_valid_i && mem_rd_i != 0 && !m_busy[mem_rd_i]) m_err = 1;
            nb = m_busy;
            if (m_we) nb[m_addr] = 1'b0;
            if (issue_valid_i && issue_rd_i != 0) nb[issue_rd_i] = 1'b1;
            if (mem_valid_i) begin
                m_we = (mem_rd_i != 0);
                if (m_we) begin m_addr = mem_rd_i; m_data = mem_data_i; end
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                m_we = 1; m_addr = e.rd; m_data = e.data;
            end else begin
                m_we = 0;
            end
            if (acc && alu_rd_i != 0) mq.push_back('{alu_rd_i, alu_data_i});
            m_busy = nb;
            m_alu_acc = acc;
        end
    end

    always @(negedge clock_i) begin
        if (!reset_i) begin
            chk("we", 32'(write_ena_o), 32'(m_we));
            if (m_we) begin
                chk("addr", 32'(W_adress_o), 32'(m_addr));
                chk("data", d_o, m_data);
            end
            chk("busy", busy_o, m_busy);
            chk("err", 32'(err_o), 32'(m_err));
            chk("ready", 32'(alu_ready_o), 32'(mq.size() < DEPTH));
        end
    end

    task automatic cyc();
        @(negedge clock_i);
    endtask

    task automatic clr();
        alu_valid_i = 0; mem_valid_i = 0; issue_valid_i = 0;
    endtask

    bit pend [32];

    initial begin
        int st, sel;
        // reset state
        cyc(); cyc();
        chk("rst_we", 32'(write_ena_o), 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", 32'(err_o), 0);
        reset_i = 0;
        cyc();
        chk("post_rst_ready", 32'(alu_ready_o), 1);

        // ALU x5 = DEADBEEF, two-cycle latency
        issue_valid_i = 1; issue_rd_i = 5; cyc();
        chk("busy5_set", 32'(busy_o[5]), 1);
        issue_valid_i = 0; alu_valid_i = 1; alu_rd_i = 5; alu_data_i = 32'hDEAD_BEEF; cyc();
        chk("t1_no_early_we", 32'(write_ena_o), 0);
        clr(); cyc();
        chk("t1_we", 32'(write_ena_o), 1);
        chk("t1_addr", 32'(W_adress_o), 5);
        chk("t1_data", d_o, 32'hDEAD_BEEF);
        cyc();
        chk("busy5_clr", 32'(busy_o[5]), 0);

        // load and ALU in the same cycle
        issue_valid_i = 1; issue_rd_i = 3; cyc();
        issue_rd_i = 4; cyc();
        issue_valid_i = 0;
        mem_valid_i = 1; mem_rd_i = 3; mem_data_i = 32'h11;
        alu_valid_i = 1; alu_rd_i = 4; alu_data_i = 32'h22; cyc();
        chk("t2_mem_addr", 32'(W_adress_o), 3);
        chk("t2_mem_data", d_o, 32'h11);
        clr(); cyc();
        chk("t2_alu_addr", 32'(W_adress_o), 4);
        chk("t2_alu_data", d_o, 32'h22);

        // FIFO fills under sustained loads, then drains in order
        for (int i = 0; i < 5; i++) begin
            issue_valid_i = 1; issue_rd_i = 5'(10 + i); cyc();
        end
        issue_valid_i = 0;
        mem_valid_i = 1; mem_rd_i = 0; mem_data_i = 32'h0;
        for (int i = 0; i < 4; i++) begin
            alu_valid_i = 1; alu_rd_i = 5'(10 + i); alu_data_i = 32'(32'h100 + i); cyc();
        end
        alu_rd_i = 14; alu_data_i = 32'h114; cyc(); cyc();
        chk("t3_full_ready", 32'(alu_ready_o), 0);
        chk("t3_full_we", 32'(write_ena_o), 0);
        clr();
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t3_drain_addr", 32'(W_adress_o), 32'(10 + i));
            chk("t3_drain_data", d_o, 32'(32'h100 + i));
        end
        alu_valid_i = 1; alu_rd_i = 14; alu_data_i = 32'h114; cyc();
        clr(); cyc();
        chk("t3_x14_addr", 32'(W_adress_o), 14);
        cyc();

        // x0 result discarded, then double issue errors
        alu_valid_i = 1; alu_rd_i = 0; alu_data_i = 32'h55; cyc();
        clr(); cyc();
        chk("t4_x0_we", 32'(write_ena_o), 0);
        chk("t4_x0_err", 32'(err_o), 0);
        issue_valid_i = 1; issue_rd_i = 7; cyc(); cyc();
        issue_valid_i = 0;
        chk("t4_double_issue_err", 32'(err_o), 1);

        // reset with three queued entries
        for (int i = 0; i < 3; i++) begin
            issue_valid_i = 1; issue_rd_i = 5'(20 + i); cyc();
        end
        issue_valid_i = 0; mem_valid_i = 1; mem_rd_i = 0;
        for (int i = 0; i < 3; i++) begin
            alu_valid_i = 1; alu_rd_i = 5'(20 + i); alu_data_i = 32'(32'h200 + i); cyc();
        end
        alu_valid_i = 0;
        #2 reset_i = 1;
        #1;
        chk("t5_rst_we", 32'(write_ena_o), 0);
        chk("t5_rst_addr", 32'(W_adress_o), 0);
        chk("t5_rst_data", d_o, 0);
        chk("t5_rst_busy", busy_o, 0);
        chk("t5_rst_err", 32'(err_o), 0);
        cyc(); clr(); reset_i = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t5_no_pulse", 32'(write_ena_o), 0);
            chk("t5_busy0", busy_o, 0);
        end

        // re-issue in the cycle the write is presented
        issue_valid_i = 1; issue_rd_i = 9; cyc();
        issue_valid_i = 0; alu_valid_i = 1; alu_rd_i = 9; alu_data_i = 32'h99; cyc();
        clr(); cyc();
        chk("t6_we", 32'(write_ena_o), 1);
        chk("t6_addr", 32'(W_adress_o), 9);
        issue_valid_i = 1; issue_rd_i = 9; cyc();
        issue_valid_i = 0;
        chk("t6_busy9", 32'(busy_o[9]), 1);
        chk("t6_err", 32'(err_o), 0);

        reset_i = 1; cyc(); cyc(); reset_i = 0; cyc();

        // random legal traffic
        for (int c = 0; c < 3000; c++) begin
            if (alu_valid_i && m_alu_acc) alu_valid_i = 0;
            mem_valid_i = 0; issue_valid_i = 0;
            st = $urandom_range(31, 0); sel = -1;
            for (int k = 0; k < 32; k++) if (sel < 0 && pend[(st + k) % 32]) sel = (st + k) % 32;
            if ($urandom_range(9, 0) < 4 && sel > 0) begin
                mem_valid_i = 1; mem_rd_i = 5'(sel); mem_data_i = $urandom; pend[sel] = 0;
            end else if ($urandom_range(9, 0) == 0) begin
                mem_valid_i = 1; mem_rd_i = 0; mem_data_i = $urandom;
            end
            if (!alu_valid_i) begin
                st = $urandom_range(31, 0); sel = -1;
                for (int k = 0; k < 32; k++) if (sel < 0 && pend[(st + k) % 32]) sel = (st + k) % 32;
                if ($urandom_range(9, 0) < 5 && sel > 0) begin
                    alu_valid_i = 1; alu_rd_i = 5'(sel); alu_data_i = $urandom; pend[sel] = 0;
                end else if ($urandom_range(9, 0) == 0) begin
                    alu_valid_i = 1; alu_rd_i = 0; alu_data_i = $urandom;
                end
            end
            if ($urandom_range(1, 0) == 1) begin
                st = $urandom_range(31, 1); sel = -1;
                for (int k = 0; k < 32; k++)
                    if (sel < 0 && (st + k) % 32 != 0 && !m_busy[(st + k) % 32] && !pend[(st + k) % 32])
                        sel = (st + k) % 32;
                if (sel > 0) begin
                    issue_valid_i = 1; issue_rd_i = 5'(sel); pend[sel] = 1;
                end
            end
            cyc();
        end
        clr();
        for (int i = 0; i < 20; i++) cyc();
        chk("rand_err_clean", 32'(err_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
